// File: rtl/fifo_rd_fwft_stage.sv
// fifo_rd_fwft_stage: 2-entry first-word-fall-through read stage for an async FIFO.
// Ports: rclk/rrst_n clock+reset; rempty/rdata/rinc to the read side;
//        out_valid/out_data/out_ready/out_count to the consumer.
module fifo_rd_fwft_stage #(
  parameter int DATASIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  output logic                out_valid,
  output logic [DATASIZE-1:0] out_data,
  input  logic                out_ready,
  output logic [1:0]          out_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic                valid;
  logic [DATASIZE-1:0] head;
  logic [DATASIZE-1:0] tail;
  logic                push;
  logic                pop;

  // rinc looks only at registered state, so out_ready never reaches it.
  assign rinc = rrst_n & ~rempty
              & (state != TWO);
  assign push = rinc;
  assign pop  = valid & out_ready;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= EMPTY;
      valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head  <= rdata;
            state <= ONE;
            valid <= 1'b1;
          end
        end
        ONE: begin
          unique case (1'b1)
            (push & pop): begin
              head <= rdata;
            end
            (push & ~pop): begin
              tail  <= rdata;
              state <= TWO;
            end
            (~push & pop): begin
              state <= EMPTY;
              valid <= 1'b0;
            end
            default: begin
            end
          endcase
        end
        TWO: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid;
  assign out_data  = head;
  assign out_count = state;

endmodule

// File: tb/tb_fifo_rd_fwft_stage.sv
// tb_fifo_rd_fwft_stage: directed + random scoreboard bench for the FWFT stage.
// Memory words offered by the bench are queued on rinc; a monitor pops on handshake.
module tb_fifo_rd_fwft_stage;

  localparam int DW = 8;
  localparam int NRAND = 1000;

  logic          rclk;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    out_count;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  int popped = 0;

  fifo_rd_fwft_stage #(.DATASIZE(DW)) dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .rempty(rempty),
    .rdata(rdata),
    .rinc(rinc),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .out_count(out_count)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at negedge, record a push if the
  // stage requests a word (it will take it at the coming posedge).
  task automatic cycle(input logic e,
                       input logic [DW-1:0] d,
                       input logic rdy);
    @(negedge rclk);
    rempty    = e;
    rdata     = e ? DW'($urandom) : d;
    out_ready = rdy;
    #2;
    if (rinc) exp_q.push_back(rdata);
  endtask

  // Monitor: checks each handshake against the scoreboard,
  // plus invariants that must hold every cycle.
  logic          prev_hold;
  logic [DW-1:0] prev_data;
  initial begin
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge rclk);
      #1;
      chk("count_legal", 32'(out_count != 2'd3), 32'd1);
      chk("no_rinc_when_empty", 32'(rinc & rempty), 32'd0);
      chk("valid_vs_count", 32'(out_valid),
          32'(out_count != 2'd0));
      if (prev_hold && out_valid)
        chk("hold_stable", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
          popped++;
        end
      end
      prev_hold = out_valid & ~out_ready;
      prev_data = out_data;
    end
  end

  initial begin
    logic [DW-1:0] src[NRAND];
    int idx;
    int budget;
    logic e;

    rrst_n    = 1'b0;
    rempty    = 1'b1;
    rdata     = '0;
    out_ready = 1'b1;

    // Reset state, including rinc forced low with rempty=0.
    for (int i = 0; i < 4; i++) begin
      cycle(i[0], DW'(8'h3C), 1'b1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_rinc", 32'(rinc), 32'd0);
    end
    exp_q.delete();
    @(negedge rclk);
    rrst_n = 1'b1;

    // Single word latency.
    cycle(1'b0, 8'hA5, 1'b0);
    chk("single_rinc", 32'(rinc), 32'd1);
    cycle(1'b1, 8'h00, 1'b0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_count", 32'(out_count), 32'd1);
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b0);
    chk("single_popped", 32'(out_count), 32'd0);

    // Full-rate stream.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, DW'(i), 1'b1);
      chk("stream_rinc", 32'(rinc), 32'd1);
      if (i > 1) chk("stream_count", 32'(out_count), 32'd1);
    end
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b0);
    chk("stream_drained", 32'(out_count), 32'd0);

    // Backpressure.
    cycle(1'b0, 8'h11, 1'b0);
    cycle(1'b0, 8'h22, 1'b0);
    cycle(1'b0, 8'h33, 1'b0);
    chk("bp_count", 32'(out_count), 32'd2);
    chk("bp_rinc", 32'(rinc), 32'd0);
    chk("bp_data", 32'(out_data), 32'h11);
    cycle(1'b0, 8'h33, 1'b0);
    chk("bp_rinc2", 32'(rinc), 32'd0);
    chk("bp_data2", 32'(out_data), 32'h11);
    cycle(1'b0, 8'h33, 1'b1);
    cycle(1'b0, 8'h33, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b0);
    chk("bp_drained", 32'(out_count), 32'd0);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while holding two words.
    cycle(1'b0, 8'h77, 1'b0);
    cycle(1'b0, 8'h88, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    chk("ar_full", 32'(out_count), 32'd2);
    #1;
    rrst_n = 1'b0;
    #1;
    chk("ar_count", 32'(out_count), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data", 32'(out_data), 32'd0);
    chk("ar_rinc", 32'(rinc), 32'd0);
    exp_q.delete();
    @(negedge rclk);
    rrst_n = 1'b1;
    cycle(1'b0, 8'h5A, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    chk("ar_first", 32'(out_data), 32'h5A);
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < NRAND; i++) src[i] = DW'($urandom);
    idx = 0;
    popped = 0;
    budget = 20000;
    while ((idx < NRAND || exp_q.size() != 0) && budget > 0) begin
      e = (idx >= NRAND) || ($urandom_range(0, 2) == 0);
      cycle(e, (idx < NRAND) ? src[idx] : '0,
            ($urandom_range(0, 3) != 0));
      if (rinc) idx++;
      budget--;
    end
    chk("rand_budget", 32'(budget > 0), 32'd1);
    repeat (2) cycle(1'b1, 8'h00, 1'b1);
    chk("rand_all_words", 32'(popped), 32'(NRAND));
    chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_fwft_stage.md
FIFO_RD_FWFT_STAGE -- requirements
Module: fifo_rd_fwft_stage

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, giving the FIFO word width in bits.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rrst_n  input  1  asynchronous active-low reset for the read domain.
REQ-004 SHALL have port rempty  input  1  registered empty flag from the read-pointer/empty block.
REQ-005 SHALL have port rdata  input  DATASIZE  memory word at the current read address; combinational (asynchronous) read, valid whenever rempty=0.
REQ-006 SHALL have port rinc  output  1  read-increment request to the read-pointer/empty block.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-008 SHALL have port out_data  output  DATASIZE  head word presented to the consumer; registered.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL have port out_count  output  2  words held in the stage (0..2); registered.

Function
REQ-011 SHALL implement a 2-entry first-word-fall-through buffer: head register (drives out_data) and tail register.
REQ-012 SHALL keep state in out_count with legal values only: EMPTY=0, ONE=1, TWO=2; value 3 never occurs.
REQ-013 SHALL drive rinc = ~rempty & (out_count != 2), forced 0 while rrst_n=0; no combinational path from out_ready to rinc.
REQ-014 SHALL define push = rinc and pop = out_valid & out_ready for the current cycle.
REQ-015 SHALL drive out_valid = (out_count != 0), registered via out_count.
REQ-016 EMPTY, push: rdata -> head, next state ONE.
REQ-017 ONE, push only: rdata -> tail, next state TWO; head unchanged.
REQ-018 ONE, pop only: next state EMPTY; head retains its last value.
REQ-019 ONE, push and pop: rdata -> head, state stays ONE (sustains one word per cycle).
REQ-020 TWO, pop: tail -> head, next state ONE; push cannot occur in TWO (REQ-013).
REQ-021 No push and no pop: all registers hold.
REQ-022 SHALL present word order exactly as read from memory; no word duplicated or dropped.
REQ-023 Latency: word with rempty=0 in cycle N appears with out_valid=1 in cycle N+1 when the stage was EMPTY.
REQ-024 out_data SHALL hold steady while out_valid=1 and out_ready=0.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 rdata SHALL be sampled only on push; rdata while rempty=1 is ignored (may be X).

Reset
REQ-027 On rrst_n low, immediately and asynchronously: out_count=0, out_valid=0, head=0, tail=0 (out_data=0); rinc=0.
REQ-028 Reset mid-operation SHALL discard buffered words; first push after release loads head per REQ-016.
REQ-029 After rrst_n deassertion, first push occurs no earlier than the first rclk edge with rempty=0.

Verification
REQ-030 Reset with rempty=1, out_ready=1 -> out_valid=0, out_count=0, out_data=0, rinc=0 for all cycles.
REQ-031 Single word 0xA5 (rempty low one cycle N) -> rinc=1 in N; cycle N+1 out_valid=1, out_data=0xA5, out_count=1; pop -> out_count=0.
REQ-032 Stream 0x01..0x10, out_ready=1 continuously, rempty=0 -> one word per cycle, out_count steady 1, order 0x01..0x10, rinc high each cycle.
REQ-033 Backpressure: out_ready=0, words 0x11,0x22,0x33 available -> out_count reaches 2, rinc drops to 0, out_data=0x11 held; release out_ready -> 0x11,0x22,0x33 in order, no loss.
REQ-034 Random rempty/out_ready toggling, 1000 words -> scoreboard matches memory order exactly; out_count never 3; no rinc while rempty=1.
REQ-035 Assert rrst_n=0 with out_count=2 -> outputs zero asynchronously (before next rclk edge); after release, new word 0x5A delivered first.
